drive_ramp_ctrl: RTL and testbench

//  Sequences the line-follower drive: ramps forward speed up after start, holds it,
//  and ramps it down on stop or a new line. Mixes the signed PID steering sum into

---
 rtl/drive_ramp_ctrl.sv | 153 +++++++++++++++
 tb/tb_drive_ramp_ctrl.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/drive_ramp_ctrl.sv
// drive_ramp_ctrl
//   Sequences the line-follower forward drive: ramps speed up after a go
//   request, holds it, and ramps it down on stop or a newly seen cross line.
//   Mixes the signed PID steering sum into left/right wheel speeds.
//
// Ports
//   clk          in   1  system clock
//   rst_n        in   1  asynchronous active-low reset
//   go           in   1  run request level; only a rising edge starts a run
//   line_present in   1  cross line seen by IR (asynchronous, synchronised here)
//   err_vld      in   1  one-cycle ramp/mix tick from the PID block
//   pid_sum      in  12  signed steering term
//   frwrd        out 10  current forward speed (unsigned)
//   moving       out  1  high whenever the sequencer is not idle
//   lft_spd      out 12  signed left wheel speed
//   rght_spd     out 12  signed right wheel speed
module drive_ramp_ctrl #(
    parameter logic [9:0] MAX_FRWRD   = 10'h2A0,
    parameter logic [9:0] FAST_THRESH = 10'h100,
    parameter logic [5:0] INC_FAST    = 6'd18,
    parameter logic [5:0] INC_SLOW    = 6'd6,
    parameter logic [5:0] DEC         = 6'd24
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        go,
    input  logic        line_present,
    input  logic        err_vld,
    input  logic [11:0] pid_sum,
    output logic [9:0]  frwrd,
    output logic        moving,
    output logic [11:0] lft_spd,
    output logic [11:0] rght_spd
);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] RAMP_UP = 2'd1;
    localparam logic [1:0] RUN     = 2'd2;
    localparam logic [1:0] RAMP_DN = 2'd3;

    logic [1:0]  state_q, state_d;
    logic [9:0]  frwrd_q, frwrd_d;
    logic        moving_q, moving_d;
    logic [11:0] lft_q, lft_d;
    logic [11:0] rght_q, rght_d;
    logic        go_q;
    logic        line_s1_q, line_s2_q, line_q;

    logic        go_rise, line_rise, stop;
    logic [5:0]  inc_sel;
    logic [10:0] up_sum;
    logic [9:0]  frwrd_up, frwrd_dn;
    logic [12:0] f_ext, pid_ext, lft_sum, rght_sum;

    // Clamp a 13-bit signed value into the 12-bit signed range.
    function automatic logic [11:0] sat12(input logic [12:0] v);
        if (v[12] != v[11])
            sat12 = v[12] ? 12'h800 : 12'h7FF;
        else
            sat12 = v[11:0];
    endfunction

    always_comb begin
        go_rise   = go & ~go_q;
        // line_s2_q is the synchronised line level; line_q is its previous value.
        line_rise = line_s2_q & ~line_q;
        stop      = ~go | line_rise;

        inc_sel  = (frwrd_q < FAST_THRESH) ? INC_FAST : INC_SLOW;
        // One extra bit so the sum cannot wrap before the ceiling clamp.
        up_sum   = {1'b0, frwrd_q} + {5'b0, inc_sel};
        frwrd_up = (up_sum >= {1'b0, MAX_FRWRD}) ? MAX_FRWRD : up_sum[9:0];
        frwrd_dn = (frwrd_q < {4'b0, DEC}) ? 10'd0 : frwrd_q - {4'b0, DEC};

        state_d = state_q;
        frwrd_d = frwrd_q;
        case (state_q)
            IDLE: begin
                frwrd_d = 10'd0;
                if (go_rise)
                    state_d = RAMP_UP;
            end
            RAMP_UP: begin
                if (err_vld)
                    frwrd_d = frwrd_up;
                // A stop request wins over reaching the ceiling.
                if (stop)
                    state_d = RAMP_DN;
                else if (frwrd_d == MAX_FRWRD)
                    state_d = RUN;
            end
            RUN: begin
                if (stop)
                    state_d = RAMP_DN;
            end
            default: begin // RAMP_DN: go and line are ignored until idle
                if (err_vld)
                    frwrd_d = frwrd_dn;
                if (frwrd_d == 10'd0)
                    state_d = IDLE;
            end
        endcase

        moving_d = (state_d != IDLE);

        // Mix uses the speed from before this tick's ramp update.
        f_ext    = {3'b0, frwrd_q};
        pid_ext  = {pid_sum[11], pid_sum};
        lft_sum  = f_ext + pid_ext;
        rght_sum = f_ext - pid_ext;

        lft_d  = lft_q;
        rght_d = rght_q;
        if (state_d == IDLE) begin
            // Wheels stop in the same clock the forward speed hits zero.
            lft_d  = 12'd0;
            rght_d = 12'd0;
        end else if (err_vld && state_q != IDLE) begin
            lft_d  = sat12(lft_sum);
            rght_d = sat12(rght_sum);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            frwrd_q   <= 10'd0;
            moving_q  <= 1'b0;
            lft_q     <= 12'd0;
            rght_q    <= 12'd0;
            go_q      <= 1'b0;
            line_s1_q <= 1'b0;
            line_s2_q <= 1'b0;
            line_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            frwrd_q   <= frwrd_d;
            moving_q  <= moving_d;
            lft_q     <= lft_d;
            rght_q    <= rght_d;
            go_q      <= go;
            line_s1_q <= line_present;
            line_s2_q <= line_s1_q;
            line_q    <= line_s2_q;
        end
    end

    assign frwrd    = frwrd_q;
    assign moving   = moving_q;
    assign lft_spd  = lft_q;
    assign rght_spd = rght_q;

endmodule

// File: tb/tb_drive_ramp_ctrl.sv
// tb_drive_ramp_ctrl
//   Directed scenarios for drive_ramp_ctrl: reset, ramp-up profile, steering
//   mix with saturation, line-triggered ramp-down, go-fall priority and
//   asynchronous reset during a ramp.
module tb_drive_ramp_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        go = 1'b0;
    logic        line_present = 1'b0;
    logic        err_vld = 1'b0;
    logic [11:0] pid_sum = 12'd0;
    logic [9:0]  frwrd;
    logic        moving;
    logic [11:0] lft_spd;
    logic [11:0] rght_spd;

    int n_checks = 0;
    int n_fail   = 0;

    drive_ramp_ctrl dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .go           (go),
        .line_present (line_present),
        .err_vld      (err_vld),
        .pid_sum      (pid_sum),
        .frwrd        (frwrd),
        .moving       (moving),
        .lft_spd      (lft_spd),
        .rght_spd     (rght_spd)
    );

    always #5 clk = ~clk;

    // One err_vld pulse, then three idle clocks; returns on a falling edge.
    task automatic pulse();
        @(negedge clk) err_vld = 1'b1;
        @(negedge clk) err_vld = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++;
        if (frwrd !== 10'd0 || moving !== 1'b0 || lft_spd !== 12'd0 || rght_spd !== 12'd0) begin
            n_fail++;
            $display("FAIL reset: frwrd=%0d moving=%b lft=%h rght=%h, want all 0", frwrd, moving, lft_spd, rght_spd);
        end
        rst_n = 1'b1;
        pulse();
        n_checks++;
        if (frwrd !== 10'd0 || moving !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_no_go: frwrd=%0d moving=%b, want 0/0", frwrd, moving);
        end
        $display("test_reset done");
    endtask

    task automatic test_ramp_up();
        logic [9:0] exp_f, prev_f;
        exp_f = 10'd0;
        pid_sum = 12'd0;
        @(negedge clk) go = 1'b1;
        @(negedge clk);
        n_checks++;
        if (moving !== 1'b1) begin
            n_fail++;
            $display("FAIL ramp_moving: moving=%b want 1", moving);
        end
        for (int i = 1; i <= 82; i++) begin
            prev_f = exp_f;
            if (exp_f < 10'd256) exp_f = exp_f + 10'd18;
            else                 exp_f = exp_f + 10'd6;
            if (exp_f > 10'd672) exp_f = 10'd672;
            pulse();
            n_checks++;
            if (frwrd !== exp_f || lft_spd !== {2'b0, prev_f} || rght_spd !== {2'b0, prev_f}) begin
                n_fail++;
                $display("FAIL ramp_step%0d: frwrd=%0d lft=%0d rght=%0d, want %0d/%0d/%0d",
                         i, frwrd, lft_spd, rght_spd, exp_f, prev_f, prev_f);
            end
            if (i == 15) begin
                n_checks++;
                if (frwrd !== 10'd270) begin
                    n_fail++;
                    $display("FAIL ramp_15th: frwrd=%0d want 270", frwrd);
                end
            end
        end
        // Now in RUN: further ticks hold the speed.
        pulse();
        n_checks++;
        if (frwrd !== 10'd672 || lft_spd !== 12'd672 || moving !== 1'b1) begin
            n_fail++;
            $display("FAIL run_hold: frwrd=%0d lft=%0d moving=%b, want 672/672/1", frwrd, lft_spd, moving);
        end
        $display("test_ramp_up done");
    endtask

    task automatic test_mix();
        pid_sum = 12'd100;
        pulse();
        n_checks++;
        if (lft_spd !== 12'd772 || rght_spd !== 12'd572) begin
            n_fail++;
            $display("FAIL mix_pos: lft=%0d rght=%0d, want 772/572", lft_spd, rght_spd);
        end
        pid_sum = 12'h7FF;
        pulse();
        n_checks++;
        if (lft_spd !== 12'h7FF || rght_spd !== 12'hAA1) begin
            n_fail++;
            $display("FAIL mix_sat_hi: lft=%h rght=%h, want 7ff/aa1", lft_spd, rght_spd);
        end
        // No tick: outputs hold even though pid_sum changes.
        pid_sum = 12'd0;
        repeat (3) @(negedge clk);
        n_checks++;
        if (lft_spd !== 12'h7FF || rght_spd !== 12'hAA1) begin
            n_fail++;
            $display("FAIL mix_hold: lft=%h rght=%h, want 7ff/aa1", lft_spd, rght_spd);
        end
        $display("test_mix done");
    endtask

    task automatic test_line_stop();
        logic [9:0] exp_f, prev_f;
        exp_f = 10'd672;
        pid_sum = 12'd0;
        @(negedge clk) line_present = 1'b1;
        repeat (4) @(negedge clk);
        for (int i = 1; i <= 28; i++) begin
            prev_f = exp_f;
            exp_f = exp_f - 10'd24;
            pulse();
            n_checks++;
            if (i < 28) begin
                if (frwrd !== exp_f || lft_spd !== {2'b0, prev_f} || moving !== 1'b1) begin
                    n_fail++;
                    $display("FAIL rampdn_step%0d: frwrd=%0d lft=%0d moving=%b, want %0d/%0d/1",
                             i, frwrd, lft_spd, moving, exp_f, prev_f);
                end
            end else begin
                if (frwrd !== 10'd0 || moving !== 1'b0 || lft_spd !== 12'd0 || rght_spd !== 12'd0) begin
                    n_fail++;
                    $display("FAIL rampdn_end: frwrd=%0d moving=%b lft=%0d rght=%0d, want 0/0/0/0",
                             frwrd, moving, lft_spd, rght_spd);
                end
            end
        end
        // go still high, no new rise: must stay idle.
        pulse();
        pulse();
        n_checks++;
        if (frwrd !== 10'd0 || moving !== 1'b0 || lft_spd !== 12'd0) begin
            n_fail++;
            $display("FAIL no_restart: frwrd=%0d moving=%b lft=%0d, want 0/0/0", frwrd, moving, lft_spd);
        end
        @(negedge clk) line_present = 1'b0;
        go = 1'b0;
        repeat (4) @(negedge clk);
        $display("test_line_stop done");
    endtask

    task automatic test_go_fall();
        logic [9:0] exp_f;
        pid_sum = 12'd0;
        @(negedge clk) go = 1'b1;
        pulse();                       // 0 -> 18
        pid_sum = 12'h800;             // -2048
        pulse();                       // 18 -> 36, mix on 18
        n_checks++;
        if (lft_spd !== 12'h812 || rght_spd !== 12'h7FF || frwrd !== 10'd36) begin
            n_fail++;
            $display("FAIL mix_sat_neg: lft=%h rght=%h frwrd=%0d, want 812/7ff/36", lft_spd, rght_spd, frwrd);
        end
        pid_sum = 12'd0;
        for (int i = 3; i <= 14; i++) pulse();
        n_checks++;
        if (frwrd !== 10'd252) begin
            n_fail++;
            $display("FAIL pre_fall: frwrd=%0d want 252", frwrd);
        end
        // go falls on the very tick clock: ramp-up rule still applies.
        @(negedge clk) begin
            go = 1'b0;
            err_vld = 1'b1;
        end
        @(negedge clk) err_vld = 1'b0;
        n_checks++;
        if (frwrd !== 10'd270 || moving !== 1'b1) begin
            n_fail++;
            $display("FAIL go_fall_tick: frwrd=%0d moving=%b, want 270/1", frwrd, moving);
        end
        // New go rise during ramp-down is ignored.
        @(negedge clk) go = 1'b1;
        exp_f = 10'd270;
        for (int i = 1; i <= 11; i++) begin
            exp_f = exp_f - 10'd24;
            pulse();
            n_checks++;
            if (frwrd !== exp_f || moving !== 1'b1) begin
                n_fail++;
                $display("FAIL fall_dn%0d: frwrd=%0d moving=%b, want %0d/1", i, frwrd, moving, exp_f);
            end
        end
        pulse();                       // 6 -> 0 (floored)
        n_checks++;
        if (frwrd !== 10'd0 || moving !== 1'b0 || lft_spd !== 12'd0) begin
            n_fail++;
            $display("FAIL fall_floor: frwrd=%0d moving=%b lft=%0d, want 0/0/0", frwrd, moving, lft_spd);
        end
        pulse();
        n_checks++;
        if (frwrd !== 10'd0 || moving !== 1'b0) begin
            n_fail++;
            $display("FAIL fall_stay_idle: frwrd=%0d moving=%b, want 0/0", frwrd, moving);
        end
        @(negedge clk) go = 1'b0;
        repeat (2) @(negedge clk);
        $display("test_go_fall done");
    endtask

    task automatic test_async_reset();
        @(negedge clk) go = 1'b1;
        for (int i = 0; i < 8; i++) pulse();
        n_checks++;
        if (frwrd !== 10'd144 || lft_spd !== 12'd126) begin
            n_fail++;
            $display("FAIL pre_reset: frwrd=%0d lft=%0d, want 144/126", frwrd, lft_spd);
        end
        #2 rst_n = 1'b0;               // between edges
        #1;
        n_checks++;
        if (frwrd !== 10'd0 || moving !== 1'b0 || lft_spd !== 12'd0 || rght_spd !== 12'd0) begin
            n_fail++;
            $display("FAIL async_reset: frwrd=%0d moving=%b lft=%0d rght=%0d, want all 0",
                     frwrd, moving, lft_spd, rght_spd);
        end
        go = 1'b0;
        @(negedge clk) rst_n = 1'b1;
        pulse();
        pulse();
        n_checks++;
        if (frwrd !== 10'd0 || moving !== 1'b0) begin
            n_fail++;
            $display("FAIL post_reset_idle: frwrd=%0d moving=%b, want 0/0", frwrd, moving);
        end
        @(negedge clk) go = 1'b1;
        pulse();
        n_checks++;
        if (frwrd !== 10'd18 || moving !== 1'b1) begin
            n_fail++;
            $display("FAIL post_reset_start: frwrd=%0d moving=%b, want 18/1", frwrd, moving);
        end
        $display("test_async_reset done");
    endtask

    initial begin
        test_reset();
        test_ramp_up();
        test_mix();
        test_line_stop();
        test_go_fall();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
